// File: rtl/spi_ram_cmd_arbiter.sv
// spi_ram_cmd_arbiter: round-robin sharing of the SPI RAM command port, one address/data beat pair per request.
// Define ADDR_SKIP_EN to drop the address beat when it repeats the last issued address of the same kind.
module spi_ram_cmd_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_SIZE = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           i_req,
    input  logic [NREQ-1:0]           i_req_wr,
    input  logic [NREQ*ADDR_SIZE-1:0] i_req_addr,
    input  logic [NREQ*ADDR_SIZE-1:0] i_req_wdata,
    output logic [NREQ-1:0]           o_gnt,
    output logic [NREQ-1:0]           o_rsp_valid,
    output logic [ADDR_SIZE-1:0]      o_rsp_data,
    output logic                      o_rsp_err,
    output logic                      o_busy,
    output logic [ADDR_SIZE+1:0]      o_ram_din,
    output logic                      o_ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]      i_ram_dout,
    input  logic                      i_ram_tx_valid
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RD_LAT + 1);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RD_WAIT} state_t;
    state_t r_st, w_nxt;
    logic [PW-1:0] r_ptr, w_win, w_idx;
    logic [CW-1:0] r_cnt, w_cnt;
    logic r_wr, r_smp_v, w_any, w_skip, w_wr, w_rxv, w_err;
    logic [ADDR_SIZE-1:0] r_wdata, r_smp, w_addr, w_wdata, w_rsp_d;
    logic [ADDR_SIZE+1:0] w_din;
    logic [NREQ-1:0] w_gnt, w_rsp_v;

    assign w_any   = |i_req;
    assign w_wr    = i_req_wr[w_win];
    assign w_addr  = i_req_addr[int'(w_win)*ADDR_SIZE +: ADDR_SIZE];
    assign w_wdata = i_req_wdata[int'(w_win)*ADDR_SIZE +: ADDR_SIZE];

    // Scan downward so the last hit is the one closest after r_ptr.
    always_comb begin
        w_win = r_ptr;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (i_req[w_idx]) w_win = w_idx;
        end
    end

`ifdef ADDR_SKIP_EN
    logic [ADDR_SIZE-1:0] r_lwa, r_lra;
    logic r_lwa_v, r_lra_v;

    assign w_skip = w_wr ? (r_lwa_v && r_lwa == w_addr) : (r_lra_v && r_lra == w_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lwa_v <= 1'b0;
            r_lra_v <= 1'b0;
            r_lwa   <= '0;
            r_lra   <= '0;
        end else if (r_st == IDLE && w_any && !w_skip) begin
            if (w_wr) {r_lwa_v, r_lwa} <= {1'b1, w_addr};
            else {r_lra_v, r_lra} <= {1'b1, w_addr};
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    always_comb begin
        w_nxt   = r_st;
        w_cnt   = '0;
        w_gnt   = '0;
        w_rsp_v = '0;
        w_rsp_d = o_rsp_data;
        w_err   = o_rsp_err;
        w_din   = '0;
        w_rxv   = 1'b0;
        case (r_st)
            IDLE: if (w_any) begin
                w_nxt = w_skip ? DATA : ADDR;
                w_gnt = NREQ'(1) << w_win;
                w_din = w_skip ? (w_wr ? {2'b01, w_wdata} : {2'b11, {ADDR_SIZE{1'b0}}})
                               : {w_wr ? 2'b00 : 2'b10, w_addr};
                w_rxv = 1'b1;
            end
            ADDR: begin
                w_nxt = DATA;
                w_din = r_wr ? {2'b01, r_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
                w_rxv = 1'b1;
            end
            DATA: begin
                w_nxt   = r_wr ? IDLE : RD_WAIT;
                w_rsp_v = r_wr ? (NREQ'(1) << r_ptr) : '0;
                w_err   = r_wr ? 1'b0 : o_rsp_err;
            end
            RD_WAIT: if (r_cnt == CW'(RD_LAT)) begin
                w_nxt   = IDLE;
                w_rsp_v = NREQ'(1) << r_ptr;
                w_rsp_d = r_smp;
                w_err   = ~r_smp_v;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st           <= IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_wr           <= 1'b0;
            r_wdata        <= '0;
            r_smp          <= '0;
            r_smp_v        <= 1'b0;
            o_gnt          <= '0;
            o_rsp_valid    <= '0;
            o_rsp_data     <= '0;
            o_rsp_err      <= 1'b0;
            o_busy         <= 1'b0;
            o_ram_din      <= '0;
            o_ram_rx_valid <= 1'b0;
        end else begin
            r_st           <= w_nxt;
            r_cnt          <= w_cnt;
            o_gnt          <= w_gnt;
            o_rsp_valid    <= w_rsp_v;
            o_rsp_data     <= w_rsp_d;
            o_rsp_err      <= w_err;
            o_busy         <= w_nxt != IDLE;
            o_ram_din      <= w_din;
            o_ram_rx_valid <= w_rxv;
            if (r_st == IDLE && w_any) begin
                r_ptr   <= w_win;
                r_wr    <= w_wr;
                r_wdata <= w_wdata;
            end
            if (r_st == RD_WAIT && r_cnt == CW'(RD_LAT - 1)) begin
                r_smp   <= i_ram_dout;
                r_smp_v <= i_ram_tx_valid;
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_cmd_arbiter.sv
// tb_spi_ram_cmd_arbiter: directed checks of the SPI RAM command arbiter against a behavioural RAM.
// The address-skip step only runs when ADDR_SKIP_EN is defined.
module tb_spi_ram_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0, req_wr = '0, gnt, rsp_valid;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  rsp_data, ram_dout = '0;
    logic        rsp_err, busy, ram_rx_valid, ram_tx_valid = 1'b0, tv_kill = 1'b0;
    logic [9:0]  ram_din;
    logic [7:0]  mem [256];
    logic [7:0]  wa = '0, ra = '0;
    logic [1:0]  seq [4];
    int nvec = 0, nfail = 0, ng, nrx, run, maxrun;

    spi_ram_cmd_arbiter #(.NREQ(2), .ADDR_SIZE(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_req_wr(req_wr), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_rsp_err(rsp_err), .o_busy(busy), .o_ram_din(ram_din), .o_ram_rx_valid(ram_rx_valid),
        .i_ram_dout(ram_dout), .i_ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    // RAM slave: 00 write addr, 01 write data, 10 read addr, 11 read (dout one cycle later)
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: wa <= ram_din[7:0];
                2'b01: mem[wa] <= ram_din[7:0];
                2'b10: ra <= ram_din[7:0];
                default: begin
                    ram_dout     <= mem[ra];
                    ram_tx_valid <= ~tv_kill;
                end
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rxv", ram_rx_valid, 0);
        rst = 1'b0;
        // write 3C <= A5 from requester 0
        req_wr = 2'b01; req_addr[7:0] = 8'h3C; req_wdata[7:0] = 8'hA5; req = 2'b01;
        @(negedge clk);
        chk("w_gnt", gnt, 2'b01);
        chk("w_addr_beat", ram_din, 10'h03C);
        chk("w_addr_rxv", ram_rx_valid, 1);
        chk("w_busy", busy, 1);
        req = 2'b00;
        @(negedge clk);
        chk("w_data_beat", ram_din, 10'h1A5);
        chk("w_data_rxv", ram_rx_valid, 1);
        chk("w_gnt_pulse", gnt, 0);
        chk("w_no_early_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("w_rsp", rsp_valid, 2'b01);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_rxv_idle", ram_rx_valid, 0);
        chk("w_busy_idle", busy, 0);
        // read 3C from requester 1
        req_wr = 2'b00; req_addr[15:8] = 8'h3C; req = 2'b10;
        @(negedge clk);
        chk("r_gnt", gnt, 2'b10);
        chk("r_addr_beat", ram_din, 10'h23C);
        req = 2'b00;
        @(negedge clk);
        chk("r_data_beat", ram_din, 10'h300);
        chk("r_data_rxv", ram_rx_valid, 1);
        @(negedge clk);
        chk("r_wait_rxv", ram_rx_valid, 0);
        chk("r_wait_busy", busy, 1);
        chk("r_wait_rsp0", rsp_valid, 0);
        @(negedge clk);
        chk("r_wait_rsp1", rsp_valid, 0);
        @(negedge clk);
        chk("r_rsp", rsp_valid, 2'b10);
        chk("r_rsp_data", rsp_data, 8'hA5);
        chk("r_rsp_err", rsp_err, 0);
        @(negedge clk);
        chk("r_rsp_pulse", rsp_valid, 0);
        chk("r_data_hold", rsp_data, 8'hA5);
        // round robin with both requesters held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_wr = 2'b11; req_addr = 16'h6050; req_wdata = 16'h6655; req = 2'b11;
        ng = 0; nrx = 0; run = 0; maxrun = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                if (ng < 4) seq[ng] = gnt;
                ng++;
            end
            run = ram_rx_valid ? run + 1 : 0;
            nrx += int'(ram_rx_valid);
            maxrun = (run > maxrun) ? run : maxrun;
            if (i == 12) req = 2'b00;
        end
        chk("rr_count", ng, 4);
        chk("rr_gnt0", seq[0], 2'b10);
        chk("rr_gnt1", seq[1], 2'b01);
        chk("rr_gnt2", seq[2], 2'b10);
        chk("rr_gnt3", seq[3], 2'b01);
        chk("rr_rxv_cycles", nrx, 8);
        chk("rr_rxv_run", maxrun, 2);
        @(negedge clk);
        // read with tx_valid stuck low
        tv_kill = 1'b1; req_wr = 2'b00; req_addr[7:0] = 8'h10; req = 2'b01;
        @(negedge clk);
        chk("e_gnt", gnt, 2'b01);
        req = 2'b00;
        for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) @(negedge clk);
        chk("e_rsp", rsp_valid, 2'b01);
        chk("e_rsp_err", rsp_err, 1);
        @(negedge clk);
        chk("e_rsp_pulse", rsp_valid, 0);
        tv_kill = 1'b0;
        req_addr[15:8] = 8'h3C; req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) @(negedge clk);
        chk("e2_rsp", rsp_valid, 2'b10);
        chk("e2_err_clear", rsp_err, 0);
        chk("e2_data", rsp_data, 8'hA5);
        @(negedge clk);
        // reset during the data beat of a write
        req_wr = 2'b01; req_addr[7:0] = 8'h20; req_wdata[7:0] = 8'h77; req = 2'b01;
        @(negedge clk);
        chk("a_gnt", gnt, 2'b01);
        req = 2'b00;
        @(negedge clk);
        chk("a_data_beat", ram_din, 10'h177);
        rst = 1'b1;
        @(negedge clk);
        chk("a_rxv", ram_rx_valid, 0);
        chk("a_busy", busy, 0);
        chk("a_rsp", rsp_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_no_rsp", rsp_valid, 0);
        end
        req = 2'b01;
        @(negedge clk);
        chk("a_regnt", gnt, 2'b01);
        chk("a_readdr", ram_din, 10'h020);
        req = 2'b00;
        repeat (3) @(negedge clk);
`ifdef ADDR_SKIP_EN
        req_wr = 2'b00; req_addr[7:0] = 8'h3C; req = 2'b01;
        @(negedge clk);
        chk("s_first_addr", ram_din, 10'h23C);
        req = 2'b00;
        for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) @(negedge clk);
        chk("s_first_data", rsp_data, 8'hA5);
        req = 2'b01;
        @(negedge clk);
        chk("s_gnt", gnt, 2'b01);
        chk("s_skip_beat", ram_din, 10'h300);
        req = 2'b00;
        for (int i = 0; i < 10 && rsp_valid == 2'b00; i++) @(negedge clk);
        chk("s_rsp", rsp_valid, 2'b01);
        chk("s_data", rsp_data, 8'hA5);
        @(negedge clk);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
